reg_bank_param: RTL and testbench

//   Parametrised bank of DEPTH registers, each WIDTH bits, with byte-enable writes.

---
 rtl/reg_bank_param.sv | 226 ++++++++++++++++++++++
 tb/tb_reg_bank_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_param.sv
// -----------------------------------------------------------------------------
// reg_bank_param
//   Parametrised bank of DEPTH words of WIDTH bits with byte-enable writes,
//   registered reads (1-cycle latency) and a sequenced bulk-clear engine that
//   zeroes one word per clock.
//
// Parameters
//   WIDTH : word width in bits, multiple of 8 (default 32)
//   DEPTH : number of words, >= 2 (default 4)
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   wr_en    in   1      write request
//   wr_addr  in   AW     write word address
//   wr_data  in   WIDTH  write data
//   wr_be    in   BE     byte enables (bit i covers wr_data[8i+7:8i])
//   wr_ack   out  1      one-cycle pulse after an accepted write
//   rd_en    in   1      read request
//   rd_addr  in   AW     read word address
//   rd_data  out  WIDTH  registered read data, holds when no read
//   rd_valid out  1      one-cycle pulse after a read request
//   clr_req  in   1      start bulk clear
//   busy     out  1      clear engine running
//
// Build option
//   RDW_BYPASS_EN : when defined, a same-edge read and write to the same valid
//                   address (not busy) returns the post-write (merged) word.
//                   Otherwise the read returns the pre-write contents.
// -----------------------------------------------------------------------------
module reg_bank_param #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [WIDTH/8-1:0]         wr_be,
    output logic                       wr_ack,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    input  logic                       clr_req,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int BE = WIDTH / 8;

    localparam logic [AW:0]   C_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1'b1);
    localparam logic [AW-1:0] C_PTR_LAST = AW'(DEPTH - 1);

    generate
        if ((WIDTH % 8) != 0) begin : g_width_chk
            $error("reg_bank_param: WIDTH must be a multiple of 8");
        end
        if (DEPTH < 2) begin : g_depth_chk
            $error("reg_bank_param: DEPTH must be at least 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Byte-lane merge: enabled lanes take new data, others keep the old word.
    function automatic logic [WIDTH-1:0] f_merge(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [BE-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < BE; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH];
    state_t           r_state;
    state_t           w_state_next;
    logic [AW-1:0]    r_clr_ptr;
    logic [AW-1:0]    w_clr_ptr_next;
    logic             r_busy;
    logic             w_busy_next;
    logic             w_clr_active;
    logic             r_wr_ack;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_wr_in_range;
    logic             w_rd_in_range;
    logic             w_wr_accept;
    logic [WIDTH-1:0] w_rd_word;

    assign w_wr_in_range = ({1'b0, wr_addr} < C_DEPTH);
    assign w_rd_in_range = ({1'b0, rd_addr} < C_DEPTH);
    // Writes are locked out for the whole clear so the engine never races a write.
    assign w_wr_accept   = wr_en & ~r_busy & w_wr_in_range;

    // Clear FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    // Clear FSM next-state and pointer logic.
    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_ptr_next = '0;
                end else begin
                    w_state_next   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // Last word zeroed this edge: pointer parks at 0, never wraps past DEPTH-1.
                if (r_clr_ptr == C_PTR_LAST) begin
                    w_state_next   = ST_IDLE;
                    w_clr_ptr_next = '0;
                end else begin
                    w_clr_ptr_next = r_clr_ptr + C_PTR_ONE;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_clr_ptr_next = '0;
            end
        endcase
    end

    // Clear FSM outputs: word-zeroing strobe and next value of the busy flag.
    always_comb begin
        w_clr_active = 1'b0;
        w_busy_next  = 1'b0;
        case (r_state)
            ST_CLEAR: w_clr_active = 1'b1;
            default:  w_clr_active = 1'b0;
        endcase
        case (w_state_next)
            ST_CLEAR: w_busy_next = 1'b1;
            default:  w_busy_next = 1'b0;
        endcase
    end

    // Registered busy flag, mirrors the CLEAR state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Storage: byte-enable writes and clear-engine zeroing (mutually exclusive).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_accept) begin
                r_mem[wr_addr] <= f_merge(r_mem[wr_addr], wr_data, wr_be);
            end
            if (w_clr_active) begin
                r_mem[r_clr_ptr] <= '0;
            end
        end
    end

    // Read word selection, including optional read-during-write bypass.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[rd_addr];
`ifdef RDW_BYPASS_EN
            if (w_wr_accept && (wr_addr == rd_addr)) begin
                w_rd_word = f_merge(r_mem[rd_addr], wr_data, wr_be);
            end else begin
                w_rd_word = r_mem[rd_addr];
            end
`endif
        end else begin
            w_rd_word = '0;
        end
    end

    // Registered read data/valid and write acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_ack   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_wr_ack   <= w_wr_accept;
            if (rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign wr_ack   = r_wr_ack;
    assign busy     = r_busy;

endmodule

// File: tb/tb_reg_bank_param.sv
module tb_reg_bank_param;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_ack;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        clr_req;
    logic        busy;

    int n_checks;
    int n_errors;

    reg_bank_param #(.WIDTH(32), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .wr_ack   (wr_ack),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_word(input logic [1:0] a, output logic [31:0] d, output logic v);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        d = rd_data;
        v = rd_valid;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        write_word(2'd0, 32'hA5A5_A5A5, 4'hF);
        rd_en = 1'b1; rd_addr = 2'd0; clr_req = 1'b1;
        tick();
        rd_en = 1'b0; clr_req = 1'b0;
        // Outputs are active here; reset asserted between edges must clear them at once.
        rst_n = 1'b0;
        #1;
        n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL reset_rd_data: got %h want 00000000", rd_data); end
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (wr_ack !== 1'b0) begin n_errors++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        #4;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            read_word(2'(i), d, v);
            n_checks++; if (d !== 32'h0 || v !== 1'b1) begin n_errors++; $display("FAIL reset_read%0d: got %h/%b want 00000000/1", i, d, v); end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        logic        v;
        write_word(2'd1, 32'hFFFF_FFFC, 4'hF);
        n_checks++; if (wr_ack !== 1'b1) begin n_errors++; $display("FAIL wr_ack_pulse: got %b want 1", wr_ack); end
        read_word(2'd1, d, v);
        n_checks++; if (wr_ack !== 1'b0) begin n_errors++; $display("FAIL wr_ack_single: got %b want 0", wr_ack); end
        n_checks++; if (d !== 32'hFFFF_FFFC || v !== 1'b1) begin n_errors++; $display("FAIL read_addr1: got %h/%b want fffffffc/1", d, v); end
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL rd_valid_drop: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL rd_data_hold: got %h want fffffffc", rd_data); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] d;
        logic        v;
        write_word(2'd2, 32'h1234_5678, 4'hF);
        write_word(2'd2, 32'hAABB_CCDD, 4'b0101);
        n_checks++; if (wr_ack !== 1'b1) begin n_errors++; $display("FAIL be_partial_ack: got %b want 1", wr_ack); end
        read_word(2'd2, d, v);
        n_checks++; if (d !== 32'h12BB_56DD) begin n_errors++; $display("FAIL be_merge: got %h want 12bb56dd", d); end
        write_word(2'd2, 32'hFFFF_FFFF, 4'h0);
        n_checks++; if (wr_ack !== 1'b1) begin n_errors++; $display("FAIL be_zero_ack: got %b want 1", wr_ack); end
        read_word(2'd2, d, v);
        n_checks++; if (d !== 32'h12BB_56DD) begin n_errors++; $display("FAIL be_zero_keep: got %h want 12bb56dd", d); end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        logic        v;
        int          busy_cnt;
        int          ack_cnt;
        for (int i = 0; i < 4; i++) write_word(2'(i), 32'h1111_1111 * (i + 1), 4'hF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
        busy_cnt = 0; ack_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (wr_ack === 1'b1) ack_cnt++;
            if (busy !== 1'b1) wr_en = 1'b0;
            tick();
        end
        wr_en = 1'b0;
        n_checks++; if (busy_cnt != 4) begin n_errors++; $display("FAIL clear_busy_len: got %0d want 4", busy_cnt); end
        n_checks++; if (ack_cnt != 0) begin n_errors++; $display("FAIL clear_wr_dropped: got %0d acks want 0", ack_cnt); end
        for (int i = 0; i < 4; i++) begin
            read_word(2'(i), d, v);
            n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL clear_read%0d: got %h want 00000000", i, d); end
        end
    endtask

    task automatic test_rdw();
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        v;
`ifdef RDW_BYPASS_EN
        exp_rd = 32'hFFFF_1FFC;
`else
        exp_rd = 32'h0000_0000;
`endif
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'hFFFF_1FFC; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 2'd0;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if (rd_data !== exp_rd || rd_valid !== 1'b1) begin n_errors++; $display("FAIL rdw_same_edge: got %h/%b want %h/1", rd_data, rd_valid, exp_rd); end
        n_checks++; if (wr_ack !== 1'b1) begin n_errors++; $display("FAIL rdw_ack: got %b want 1", wr_ack); end
        read_word(2'd0, d, v);
        n_checks++; if (d !== 32'hFFFF_1FFC) begin n_errors++; $display("FAIL rdw_after: got %h want ffff1ffc", d); end
    endtask

    task automatic test_clear_write_same_edge();
        logic [31:0] d;
        logic        v;
        int          busy_cnt;
        clr_req = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'hFF8F_1FFC; wr_be = 4'hF;
        tick();
        clr_req = 1'b0; wr_en = 1'b0;
        n_checks++; if (wr_ack !== 1'b1) begin n_errors++; $display("FAIL clrwr_ack: got %b want 1", wr_ack); end
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
        end
        n_checks++; if (busy_cnt != 4) begin n_errors++; $display("FAIL clrwr_busy_len: got %0d want 4", busy_cnt); end
        read_word(2'd1, d, v);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL clrwr_addr1: got %h want 00000000", d); end
        read_word(2'd0, d, v);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL clrwr_addr0: got %h want 00000000", d); end
    endtask

    task automatic test_back_to_back();
        write_word(2'd2, 32'h1111_2222, 4'hF);
        write_word(2'd3, 32'h3333_4444, 4'hF);
        rd_en = 1'b1; rd_addr = 2'd2;
        tick();
        n_checks++; if (rd_data !== 32'h1111_2222 || rd_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_first: got %h/%b want 11112222/1", rd_data, rd_valid); end
        rd_addr = 2'd3;
        tick();
        rd_en = 1'b0;
        n_checks++; if (rd_data !== 32'h3333_4444 || rd_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_second: got %h/%b want 33334444/1", rd_data, rd_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 32'h0; wr_be = 4'h0;
        rd_en = 1'b0; rd_addr = 2'd0; clr_req = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_write_read();
        test_byte_enable();
        test_clear();
        test_rdw();
        test_clear_write_same_edge();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
